// File: rtl/amba4_apb_mem_slave.sv
// APB4 slave memory with byte strobes, pprot write protection, programmable wait
// states and PSLVERR for out-of-range, misaligned or protection-violating accesses.
module amba4_apb_mem_slave #(
  parameter int                    ADDR_SIZE  = 32,
  parameter int                    DATA_SIZE  = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_SIZE-1:0]  BASE_ADDR  = '0,
  parameter bit                    PRIV_WRITE = 1'b0
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_SIZE-1:0]   paddr,
  input  logic [DATA_SIZE-1:0]   pwdata,
  input  logic [DATA_SIZE/8-1:0] pstrb,
  input  logic [2:0]             pprot,
  input  logic [3:0]             wait_cfg,
  output logic                   pready,
  output logic [DATA_SIZE-1:0]   prdata,
  output logic                   pslverr,
  output logic [15:0]            xfer_cnt
);

  localparam int NB        = DATA_SIZE / 8;
  localparam int DATA_BASE = $clog2(NB);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               state_reg;
  logic [3:0]           cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic                 wr_reg;
  logic                 err_reg;
  logic [DATA_SIZE-1:0] wdata_reg;
  logic [NB-1:0]        strb_reg;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] off_live;
  logic [IDX_W-1:0]     idx_live;
  logic                 err_live;
  logic [IDX_W-1:0]     rd_idx;
  logic [DATA_SIZE-1:0] rd_word;
  logic                 mem_we;
  logic [NB-1:0]        lane_we;
  logic                 unused_prot;

  // Only pprot[0] (privileged) takes part in access checking.
  assign unused_prot = ^pprot[2:1];

  assign off_live = paddr - BASE_ADDR;
  assign idx_live = off_live[DATA_BASE +: IDX_W];
  assign err_live = (paddr < BASE_ADDR)
                 || ((off_live >> (DATA_BASE + IDX_W)) != '0)
                 || ((paddr & ALIGN_MASK) != '0)
                 || (PRIV_WRITE && pwrite && !pprot[0]);

  // The setup-phase address feeds the read port directly so a zero-wait
  // read has its data registered in time for the first access cycle.
  assign rd_idx  = (state_reg == S_IDLE) ? idx_live : idx_reg;
  assign rd_word = mem[rd_idx];

  assign mem_we = (state_reg == S_DONE) && psel && penable && wr_reg && !err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane_we
      assign lane_we[gi] = mem_we && strb_reg[gi];
    end
  endgenerate

  always_ff @(posedge pclk) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) mem[idx_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      wr_reg    <= 1'b0;
      err_reg   <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      xfer_cnt  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (psel && !penable) begin
            idx_reg   <= idx_live;
            wr_reg    <= pwrite;
            err_reg   <= err_live;
            wdata_reg <= pwdata;
            strb_reg  <= pstrb;
            cnt_reg   <= wait_cfg;
            if (wait_cfg == 4'd0) begin
              state_reg <= S_DONE;
              pready    <= 1'b1;
              pslverr   <= err_live;
              prdata    <= (!err_live && !pwrite) ? rd_word : '0;
            end else begin
              state_reg <= S_WAIT;
              pready    <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (!(psel && penable)) begin
            state_reg <= S_IDLE;
          end else if (cnt_reg == 4'd1) begin
            state_reg <= S_DONE;
            pready    <= 1'b1;
            pslverr   <= err_reg;
            prdata    <= (!err_reg && !wr_reg) ? rd_word : '0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_DONE: begin
          // A master that dropped psel/penable here abandons the transfer uncounted.
          if (psel && penable) xfer_cnt <= xfer_cnt + 16'd1;
          state_reg <= S_IDLE;
          pready    <= 1'b0;
          pslverr   <= 1'b0;
          prdata    <= '0;
        end
        default: begin
          state_reg <= S_IDLE;
          pready    <= 1'b0;
          pslverr   <= 1'b0;
          prdata    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amba4_apb_mem_slave.sv
// Randomised scoreboard bench for amba4_apb_mem_slave: a driver issues APB4 transfers and
// queues expected responses from a word-array model; a negedge monitor checks them.
module tb_amba4_apb_mem_slave;
  localparam int DEPTH = 1024;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic [3:0]  wait_cfg = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [15:0] xfer_cnt;

  amba4_apb_mem_slave #(
    .ADDR_SIZE(32), .DATA_SIZE(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0), .PRIV_WRITE(1'b1)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .wait_cfg(wait_cfg),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .xfer_cnt(xfer_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [DEPTH];
  int          exp_xfer = 0;
  int          acc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic bit model_err(input logic [31:0] addr, input logic wr, input logic [2:0] prot);
    return (addr % 4 != 0) || (addr / 4 >= DEPTH) || (wr && !prot[0]);
  endfunction

  // Monitor: counts low access cycles and checks each completed response.
  always @(negedge pclk) begin : mon
    exp_t e;
    if (!preset && psel) begin
      if (!penable) acc_cnt = 0;
      else if (pready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pready: got pready=1, expected no transfer pending");
        end else begin
          e = exp_q.pop_front();
          $display("txn %-16s prdata=%08h pslverr=%0b waits=%0d", e.name, prdata, pslverr, acc_cnt);
          check({e.name, "_prdata"}, prdata, e.rdata);
          check({e.name, "_pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
          check({e.name, "_waits"}, 32'(acc_cnt), 32'(e.waits));
        end
      end else acc_cnt++;
    end
  end

  // abort_mode: 0 = normal, 1 = assert preset after abort_at access edges, 2 = drop psel.
  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [3:0] wcfg, input int abort_mode = 0, input int abort_at = 0);
    exp_t e;
    bit   err;
    int   n;
    err = model_err(addr, wr, prot);
    if (abort_mode == 0) begin
      e.name  = name;
      e.err   = err;
      e.waits = int'(wcfg);
      e.rdata = (!wr && !err) ? ref_mem[addr / 4] : 32'h0;
      exp_q.push_back(e);
      if (wr && !err)
        for (int i = 0; i < 4; i++)
          if (strb[i]) ref_mem[addr / 4][8*i +: 8] = data[8*i +: 8];
      exp_xfer++;
    end
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; pprot = prot; wait_cfg = wcfg;
    @(posedge pclk); #1;
    penable  = 1'b1;
    wait_cfg = 4'($urandom);
    if (abort_mode != 0) begin
      repeat (abort_at) @(posedge pclk);
      #1;
      if (abort_mode == 1) begin
        preset = 1'b1;
        repeat (5) @(posedge pclk);
        #1;
        check({name, "_pready_in_reset"}, {31'b0, pready}, 32'h0);
        check({name, "_xfer_cnt_in_reset"}, {16'h0, xfer_cnt}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        preset = 1'b0;
        exp_xfer = 0;
      end else begin
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check({name, "_pready_after_drop"}, {31'b0, pready}, 32'h0);
      end
    end else begin
      n = 0;
      while (1) begin
        @(negedge pclk);
        if (pready === 1'b1) break;
        n++;
        if (n > 40) break;
      end
      if (n > 40) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: got no pready in 40 cycles, expected %0d wait states", name, wcfg);
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic check_cnt(input string name);
    check({name, "_xfer_cnt"}, {16'h0, xfer_cnt}, {16'h0, 16'(exp_xfer)});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] addrs[$];
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_pready",   {31'b0, pready},  32'h0);
    check("reset_pslverr",  {31'b0, pslverr}, 32'h0);
    check("reset_prdata",   prdata,           32'h0);
    check("reset_xfer_cnt", {16'h0, xfer_cnt}, 32'h0);
    preset = 1'b0;

    xfer("pre40", 1'b1, 32'h40, 32'h11112222, 4'hF, 3'b001, 4'd0);
    xfer("rst_abort", 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 3'b001, 4'd10, 1, 2);
    check_cnt("after_reset");
    xfer("rd40_post_rst", 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, 4'd2);

    xfer("wr800_w0", 1'b1, 32'h800, 32'h00040000, 4'hF, 3'b001, 4'd0);
    xfer("rd800_w0", 1'b0, 32'h800, 32'h0, 4'h0, 3'b001, 4'd0);
    check_cnt("zero_wait");

    xfer("wr84", 1'b1, 32'h84, 32'h04400011, 4'hF, 3'b001, 4'd1);
    xfer("rd84_w3", 1'b0, 32'h84, 32'h0, 4'h0, 3'b001, 4'd3);
    xfer("rd84_w15", 1'b0, 32'h84, 32'h0, 4'h0, 3'b001, 4'd15);

    xfer("wr40_full", 1'b1, 32'h40, 32'h80003333, 4'hF, 3'b001, 4'd1);
    xfer("wr40_strb5", 1'b1, 32'h40, 32'h12345678, 4'h5, 3'b001, 4'd2);
    xfer("rd40_strb", 1'b0, 32'h40, 32'h0, 4'hA, 3'b001, 4'd0);

    xfer("rd_misalign", 1'b0, 32'h42, 32'h0, 4'h0, 3'b001, 4'd1);
    xfer("wr_oor", 1'b1, 32'(DEPTH * 4), 32'h1, 4'hF, 3'b001, 4'd2);
    xfer("wr18_priv", 1'b1, 32'h18, 32'h0BADF00D, 4'hF, 3'b001, 4'd0);
    xfer("wr18_unpriv", 1'b1, 32'h18, 32'h22446688, 4'hF, 3'b000, 4'd1);
    xfer("rd18", 1'b0, 32'h18, 32'h0, 4'h0, 3'b011, 4'd0);
    xfer("wr18_strb0", 1'b1, 32'h18, 32'hFFFFFFFF, 4'h0, 3'b001, 4'd0);
    xfer("rd18_strb0", 1'b0, 32'h18, 32'h0, 4'h0, 3'b001, 4'd4);

    xfer("drop_in_wait", 1'b1, 32'h18, 32'h55555555, 4'hF, 3'b001, 4'd6, 2, 2);
    xfer("drop_in_done", 1'b1, 32'h18, 32'h66666666, 4'hF, 3'b001, 4'd2, 2, 2);
    check_cnt("after_drops");
    xfer("rd18_drop", 1'b0, 32'h18, 32'h0, 4'h0, 3'b001, 4'd0);

    repeat (1000) begin
      a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      addrs.push_back(a);
      xfer("rnd_wr", 1'b1, a, $urandom, 4'($urandom), {2'($urandom), 1'b1}, 4'($urandom));
    end
    foreach (addrs[i])
      xfer("rnd_rd", 1'b0, addrs[i], 32'h0, 4'($urandom), {2'($urandom), 1'b1}, 4'($urandom));
    check_cnt("final");

    repeat (3) @(posedge pclk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
